// File: rtl/emd_pkg.sv
// ============================================================================
// Module : emd_pkg
// Shared sample/count types and sifting-decision FSM states for the EMD path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package emd_pkg;

    localparam int DATA_W    = 16;
    localparam int CNT_W_DEF = 9;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [CNT_W_DEF-1:0]     count_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DECIDE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/extrema_zc_detect.sv
// ============================================================================
// Module : extrema_zc_detect
// 3-sample window; flags judge the middle sample (extrema) and the last step (zc).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module extrema_zc_detect
    import emd_pkg::*;
(
    input  logic    CLK,
    input  logic    RST_N,
    input  logic    clear,
    input  logic    accept,
    input  sample_t h_in,
    output logic    is_max,
    output logic    is_min,
    output logic    is_zc
);

    sample_t    w1;
    sample_t    w2;
    logic [1:0] fill;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w1   <= '0;
            w2   <= '0;
            fill <= 2'd0;
        end else if (clear) begin
            // A restarting sample becomes h[0] of the new frame
            w2   <= '0;
            w1   <= accept ? h_in : '0;
            fill <= accept ? 2'd1 : 2'd0;
        end else if (accept) begin
            w2 <= w1;
            w1 <= h_in;
            if (fill != 2'd2)
                fill <= fill + 2'd1;
        end
    end

    assign is_max = (fill == 2'd2) && (w1 > w2) && (w1 >= h_in);
    assign is_min = (fill == 2'd2) && (w1 < w2) && (w1 <= h_in);
    assign is_zc  = (fill != 2'd0) && (w1[DATA_W-1] != h_in[DATA_W-1]);

endmodule

`default_nettype wire

// File: rtl/imf_sift_check.sv
// ============================================================================
// Module : imf_sift_check
// Counts extrema/zero crossings of one h(t) frame and issues the sift decision.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imf_sift_check
    import emd_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = 9,
    parameter int MAX_ITER  = 10,
    parameter int ITER_W    = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     start,
    input  logic                     new_mode,
    input  logic signed [DATA_W-1:0] h_in,
    input  logic                     h_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     is_imf,
    output logic                     sift_again,
    output logic                     forced,
    output logic [CNT_W-1:0]         n_max,
    output logic [CNT_W-1:0]         n_min,
    output logic [CNT_W-1:0]         n_zc,
    output logic [ITER_W-1:0]        iter_cnt
);

    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]    EXT_ONE  = (CNT_W+1)'(1);
    localparam logic [ITER_W:0]   ITER_CAP = (ITER_W+1)'(MAX_ITER);

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] cnt_max;
    logic [CNT_W-1:0] cnt_min;
    logic [CNT_W-1:0] cnt_zc;

    logic             det_accept;
    logic             is_max;
    logic             is_min;
    logic             is_zc;

    logic [CNT_W:0]   ext;
    logic [CNT_W:0]   zc_ext;
    logic             ok;
    logic [ITER_W:0]  iter_inc;
    logic             cap;
    logic [ITER_W-1:0] iter_next;
    logic             accept_imf;

    assign det_accept = h_valid && (start || (state == RUN));

    extrema_zc_detect u_detect (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clear  (start),
        .accept (det_accept),
        .h_in   (h_in),
        .is_max (is_max),
        .is_min (is_min),
        .is_zc  (is_zc)
    );

    assign busy = (state != IDLE);

    always_comb begin
        ext        = {1'b0, cnt_max} + {1'b0, cnt_min};
        zc_ext     = {1'b0, cnt_zc};
        ok         = (ext >= zc_ext) ? ((ext - zc_ext) <= EXT_ONE)
                                     : ((zc_ext - ext) <= EXT_ONE);
        iter_inc   = {1'b0, iter_cnt} + (ITER_W+1)'(1);
        cap        = (iter_inc >= ITER_CAP);
        iter_next  = cap ? ITER_W'(MAX_ITER) : iter_inc[ITER_W-1:0];
        accept_imf = ok || cap;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            idx        <= '0;
            cnt_max    <= '0;
            cnt_min    <= '0;
            cnt_zc     <= '0;
            done       <= 1'b0;
            is_imf     <= 1'b0;
            sift_again <= 1'b0;
            forced     <= 1'b0;
            n_max      <= '0;
            n_min      <= '0;
            n_zc       <= '0;
            iter_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state   <= RUN;
                idx     <= h_valid ? CNT_ONE : '0;
                cnt_max <= '0;
                cnt_min <= '0;
                cnt_zc  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    RUN: begin
                        if (h_valid) begin
                            idx <= idx + CNT_ONE;
                            if (is_max && (cnt_max != '1)) cnt_max <= cnt_max + CNT_ONE;
                            if (is_min && (cnt_min != '1)) cnt_min <= cnt_min + CNT_ONE;
                            if (is_zc  && (cnt_zc  != '1)) cnt_zc  <= cnt_zc  + CNT_ONE;
                            if (idx == LAST_IDX)
                                state <= DECIDE;
                        end
                    end
                    DECIDE: begin
                        n_max      <= cnt_max;
                        n_min      <= cnt_min;
                        n_zc       <= cnt_zc;
                        is_imf     <= accept_imf;
                        sift_again <= !accept_imf;
                        forced     <= accept_imf && !ok;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            // done/is_imf here are the previous cycle's registered values
            if (new_mode)
                iter_cnt <= '0;
            else if (!start && (state == DECIDE))
                iter_cnt <= iter_next;
            else if (done && is_imf)
                iter_cnt <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imf_sift_check.sv
// ============================================================================
// Module : tb_imf_sift_check
// Self-checking bench: directed frames plus random frames against a frame model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imf_sift_check;

    localparam int FL  = 8;
    localparam int MI  = 3;

    typedef logic signed [15:0] frame_t [FL];

    typedef struct {
        bit         early_done;
        int         lat;
        logic       is_imf;
        logic       sift_again;
        logic       forced;
        logic [3:0] n_max;
        logic [3:0] n_min;
        logic [3:0] n_zc;
        logic [1:0] iter_done;
        logic [1:0] iter_after;
        logic       done_after;
    } obs_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               new_mode;
    logic signed [15:0] h_in;
    logic               h_valid;
    logic               busy, done, is_imf, sift_again, forced;
    logic [3:0]         n_max, n_min, n_zc;
    logic [1:0]         iter_cnt;

    int errors = 0;
    int checks = 0;
    int model_iter = 0;

    frame_t SINE   = '{16'sd0, 16'sd100, 16'sd0, -16'sd100, 16'sd0, 16'sd100, 16'sd0, -16'sd100};
    frame_t RIDING = '{16'sd10, 16'sd50, 16'sd20, 16'sd60, 16'sd30, 16'sd70, 16'sd40, 16'sd80};

    imf_sift_check #(.FRAME_LEN(FL), .CNT_W(4), .MAX_ITER(MI), .ITER_W(2)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .start      (start),
        .new_mode   (new_mode),
        .h_in       (h_in),
        .h_valid    (h_valid),
        .busy       (busy),
        .done       (done),
        .is_imf     (is_imf),
        .sift_again (sift_again),
        .forced     (forced),
        .n_max      (n_max),
        .n_min      (n_min),
        .n_zc       (n_zc),
        .iter_cnt   (iter_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Counts straight from the definitions: interior peaks/troughs and sign changes
    function automatic void model_counts(input frame_t s, output int mx, output int mn, output int zc);
        mx = 0; mn = 0; zc = 0;
        for (int i = 1; i < FL - 1; i++) begin
            if (s[i] > s[i-1] && s[i] >= s[i+1]) mx++;
            if (s[i] < s[i-1] && s[i] <= s[i+1]) mn++;
        end
        for (int i = 1; i < FL; i++)
            if ((s[i] < 0) != (s[i-1] < 0)) zc++;
    endfunction

    // Decision for a frame; advances the per-mode sift count
    function automatic void model_decide(input int mx, input int mn, input int zc,
                                         output bit imf, output bit frc,
                                         output int it_done, output int it_after);
        bit ok;
        ok       = ((mx + mn - zc) >= -1) && ((mx + mn - zc) <= 1);
        imf      = ok || (model_iter + 1 >= MI);
        frc      = imf && !ok;
        it_done  = (model_iter + 1 > MI) ? MI : model_iter + 1;
        it_after = imf ? 0 : it_done;
        model_iter = it_after;
    endfunction

    task automatic send_frame(input frame_t s, input int stall_mode, output obs_t o);
        o.early_done = 0;
        o.lat        = 0;
        @(negedge clk);
        start = 1'b1; h_valid = 1'b1; h_in = s[0];
        for (int i = 1; i < FL; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) o.early_done = 1;
            if (stall_mode == 1 || (stall_mode == 2 && $urandom_range(0, 2) == 0)) begin
                h_valid = 1'b0;
                h_in    = 16'(int'($urandom));
                @(negedge clk);
                if (done) o.early_done = 1;
            end
            h_valid = 1'b1; h_in = s[i];
        end
        @(negedge clk);
        h_valid = 1'b0;
        if (done) o.early_done = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            o.lat++;
            if (done === 1'b1) break;
        end
        o.is_imf = is_imf; o.sift_again = sift_again; o.forced = forced;
        o.n_max = n_max; o.n_min = n_min; o.n_zc = n_zc; o.iter_done = iter_cnt;
        @(negedge clk);
        o.iter_after = iter_cnt;
        o.done_after = done;
    endtask

    task automatic pulse_new_mode();
        @(negedge clk); new_mode = 1'b1;
        @(negedge clk); new_mode = 1'b0;
        model_iter = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; new_mode = 1'b0; h_valid = 1'b0; h_in = '0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, is_imf, sift_again, forced, n_max, n_min, n_zc, iter_cnt} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0",
                {busy, done, is_imf, sift_again, forced, n_max, n_min, n_zc, iter_cnt}); end
        rst_n = 1'b1;
        model_iter = 0;
    endtask

    task automatic test_sine(input int stall_mode);
        obs_t o;
        send_frame(SINE, stall_mode, o);
        checks++; if (o.early_done || o.lat != 1) begin errors++;
            $display("FAIL sine_latency(stall=%0d): got lat=%0d early=%0d expected lat=1 early=0", stall_mode, o.lat, o.early_done); end
        checks++; if ({o.n_max, o.n_min, o.n_zc} !== {4'd2, 4'd1, 4'd3}) begin errors++;
            $display("FAIL sine_counts: got max=%0d min=%0d zc=%0d expected 2 1 3", o.n_max, o.n_min, o.n_zc); end
        checks++; if ({o.is_imf, o.sift_again, o.forced} !== 3'b100) begin errors++;
            $display("FAIL sine_decision: got imf/sift/forced=%b expected 100", {o.is_imf, o.sift_again, o.forced}); end
        checks++; if (o.iter_done !== 2'd1 || o.iter_after !== 2'd0 || o.done_after !== 1'b0) begin errors++;
            $display("FAIL sine_iter: got iter=%0d then %0d done_after=%0d expected 1 then 0, 0", o.iter_done, o.iter_after, o.done_after); end
        model_iter = 0;
    endtask

    task automatic test_iter_cap();
        obs_t o;
        pulse_new_mode();
        for (int f = 1; f <= MI; f++) begin
            send_frame(RIDING, 0, o);
            checks++; if (o.lat != 1 || {o.n_max, o.n_min, o.n_zc} !== {4'd3, 4'd3, 4'd0}) begin errors++;
                $display("FAIL riding_counts(f%0d): got lat=%0d max=%0d min=%0d zc=%0d expected 1 3 3 0", f, o.lat, o.n_max, o.n_min, o.n_zc); end
            checks++; if ({o.is_imf, o.sift_again, o.forced} !== ((f < MI) ? 3'b010 : 3'b101)) begin errors++;
                $display("FAIL riding_decision(f%0d): got imf/sift/forced=%b expected %b", f,
                    {o.is_imf, o.sift_again, o.forced}, (f < MI) ? 3'b010 : 3'b101); end
            checks++; if (o.iter_done !== 2'(f) || o.iter_after !== ((f < MI) ? 2'(f) : 2'd0)) begin errors++;
                $display("FAIL riding_iter(f%0d): got %0d then %0d expected %0d then %0d", f, o.iter_done, o.iter_after,
                    f, (f < MI) ? f : 0); end
        end
        model_iter = 0;
    endtask

    task automatic test_restart();
        obs_t o;
        bit   stray;
        stray = 0;
        @(negedge clk); start = 1'b1; h_valid = 1'b1; h_in = 16'sd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); start = 1'b0; h_in = 16'(int'($urandom_range(0, 200)) - 100);
            if (done) stray = 1;
        end
        send_frame(RIDING, 0, o);
        repeat (4) begin @(negedge clk); if (done) stray = 1; end
        checks++; if (stray || o.early_done || o.done_after) begin errors++;
            $display("FAIL restart_single_done: got extra done (stray=%0d early=%0d after=%0d) expected one done", stray, o.early_done, o.done_after); end
        checks++; if (o.lat != 1 || {o.n_max, o.n_min, o.n_zc} !== {4'd3, 4'd3, 4'd0} || o.sift_again !== 1'b1) begin errors++;
            $display("FAIL restart_counts: got lat=%0d max=%0d min=%0d zc=%0d sift=%0d expected 1 3 3 0 1",
                o.lat, o.n_max, o.n_min, o.n_zc, o.sift_again); end
        checks++; if (iter_cnt !== 2'd1) begin errors++;
            $display("FAIL restart_iter: got %0d expected 1", iter_cnt); end
        pulse_new_mode();
        @(negedge clk);
        checks++; if (iter_cnt !== 2'd0) begin errors++;
            $display("FAIL new_mode_clear: got %0d expected 0", iter_cnt); end
    endtask

    task automatic test_reset_midframe();
        bit stray;
        stray = 0;
        @(negedge clk); start = 1'b1; h_valid = 1'b1; h_in = 16'sd7;
        for (int i = 0; i < 4; i++) begin @(negedge clk); start = 1'b0; h_in = 16'(-i * 9); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %0d expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, is_imf, sift_again, forced, n_max, n_min, n_zc, iter_cnt} !== '0) begin errors++;
            $display("FAIL midframe_reset_outputs: got %h expected 0",
                {busy, done, is_imf, sift_again, forced, n_max, n_min, n_zc, iter_cnt}); end
        @(negedge clk); rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (done) stray = 1; end
        h_valid = 1'b0;
        checks++; if (stray) begin errors++; $display("FAIL midframe_no_done: got done expected none"); end
        model_iter = 0;
    endtask

    task automatic test_random();
        obs_t   o;
        frame_t s;
        int     mx, mn, zc, itd, ita;
        bit     imf, frc;
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 3) == 0) pulse_new_mode();
            for (int i = 0; i < FL; i++)
                s[i] = 16'(int'($urandom_range(0, 8)) - 4) * 16'sd1000;
            model_counts(s, mx, mn, zc);
            model_decide(mx, mn, zc, imf, frc, itd, ita);
            send_frame(s, 2, o);
            checks++; if (o.early_done || o.lat != 1) begin errors++;
                $display("FAIL rand_latency(f%0d): got lat=%0d early=%0d expected 1 0", f, o.lat, o.early_done); end
            checks++; if (o.n_max != 4'(mx) || o.n_min != 4'(mn) || o.n_zc != 4'(zc)) begin errors++;
                $display("FAIL rand_counts(f%0d): got %0d %0d %0d expected %0d %0d %0d", f, o.n_max, o.n_min, o.n_zc, mx, mn, zc); end
            checks++; if (o.is_imf !== imf || o.sift_again !== !imf || o.forced !== frc) begin errors++;
                $display("FAIL rand_decision(f%0d): got imf/sift/forced=%b expected %b%b%b", f,
                    {o.is_imf, o.sift_again, o.forced}, imf, !imf, frc); end
            checks++; if (o.iter_done != 2'(itd) || o.iter_after != 2'(ita)) begin errors++;
                $display("FAIL rand_iter(f%0d): got %0d then %0d expected %0d then %0d", f, o.iter_done, o.iter_after, itd, ita); end
        end
    endtask

    initial begin
        test_reset();
        test_sine(0);
        test_iter_cap();
        test_sine(1);
        test_restart();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
